// File: rtl/dual_mem_accumulator_if.sv
// Shared memory read bus: one address/enable driven by the accumulator,
// concatenated read data returned by N_CH synchronous-read memories.
interface dual_mem_accumulator_if #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3
);
    logic                     mem_en;
    logic [ADDR_W-1:0]        mem_addr;
    logic [N_CH*DATA_W-1:0]   mem_rdata;

    modport master (output mem_en, output mem_addr, input  mem_rdata);
    modport slave  (input  mem_en, input  mem_addr, output mem_rdata);
endinterface

// File: rtl/dual_mem_accumulator.sv
// Walks an address window across N_CH shared-address memories and sums every
// channel word into one wrap/saturate accumulator; one-cycle done on completion.
module dual_mem_accumulator #(
    parameter int N_CH   = 2,
    parameter int DATA_W = 4,
    parameter int ADDR_W = 3,
    parameter int ACC_W  = 16,
    parameter int RD_LAT = 1
) (
    input  logic                 clock,
    input  logic                 clear_n,
    input  logic                 start,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      len,
    input  logic                 sat_en,
    dual_mem_accumulator_if.master mem,
    output logic                 busy,
    output logic                 done,
    output logic [ACC_W-1:0]     sum,
    output logic                 overflow,
    output logic [1:0]           dbg_state_o
);

    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [ADDR_W:0]     cnt_q, cnt_d;
    logic [ADDR_W:0]     len_q, len_d;
    logic                sat_q, sat_d;
    logic [ACC_W-1:0]    acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [RD_LAT-1:0]   vpipe_q, vpipe_d;
    logic [ACC_W:0]      term;
    logic [ACC_W:0]      acc_next;
    logic                issue;

    assign issue = (state_q == ISSUE);

    // Control protocol: start is sampled only in IDLE; busy covers ISSUE and
    // DRAIN; done is a single-cycle pulse in FIN, after which sum/overflow hold.
    always_comb begin
        term = '0;
        for (int c = 0; c < N_CH; c++) begin
            term = term + (ACC_W+1)'(mem.mem_rdata[c*DATA_W +: DATA_W]);
        end
        acc_next = {1'b0, acc_q} + term;

        vpipe_d[0] = issue;
        for (int i = 1; i < RD_LAT; i++) begin
            vpipe_d[i] = vpipe_q[i-1];
        end

        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        sat_d   = sat_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;

        if (vpipe_q[RD_LAT-1]) begin
            if (acc_next[ACC_W]) begin
                ovf_d = 1'b1;
                acc_d = sat_q ? '1 : acc_next[ACC_W-1:0];
            end else begin
                acc_d = acc_next[ACC_W-1:0];
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    len_d   = len;
                    sat_d   = sat_en;
                    addr_d  = base_addr;
                    cnt_d   = '0;
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    // An empty window passes through DRAIN with an empty pipe,
                    // giving done one cycle after the first post-start edge.
                    state_d = (len != '0) ? ISSUE : DRAIN;
                end
            end
            ISSUE: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == (len_q - 1'b1)) begin
                    state_d = DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            DRAIN: begin
                if (vpipe_d == '0) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            len_q   <= '0;
            sat_q   <= 1'b0;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            vpipe_q <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            sat_q   <= sat_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            vpipe_q <= vpipe_d;
        end
    end

    assign mem.mem_en   = issue;
    assign mem.mem_addr = addr_q;
    assign busy         = (state_q == ISSUE) || (state_q == DRAIN);
    assign done         = (state_q == FIN);
    assign sum          = acc_q;
    assign overflow     = ovf_q;
    assign dbg_state_o  = state_q;

endmodule
